// File: rtl/fifo_rd_arb_pkg.sv
// Shared definitions for the FIFO read-side arbiter and its round-robin picker.
//   arb_state_e : arbiter FSM states (idle, burst in progress, burst wrap-up)
//   idx_w       : width of a consumer index for n consumers (at least 1 bit)
//   stall_w     : width of a stall counter that must be able to hold t
//   rst_ptr     : reset value of the round-robin pointer (last consumer, so consumer 0 wins first)
package fifo_rd_arb_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StBurst = 2'd1,
      StDone  = 2'd2
   } arb_state_e;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned stall_w(input int unsigned t);
      return (t > 0) ? $clog2(t + 1) : 1;
   endfunction

   function automatic int unsigned rst_ptr(input int unsigned n);
      return n - 1;
   endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// Searches req upward from ptr+1 with wrap-around and returns the first set bit.
//   req      : request vector
//   ptr      : index of the most recently served requester
//   pick     : one-hot winner (all zero when nothing requests)
//   pick_idx : binary index of the winner
//   valid    : at least one request was present
module rr_pick
   import fifo_rd_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned PW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] pick,
   output logic [PW-1:0]   pick_idx,
   output logic            valid
);

   always_comb begin
      logic [PW-1:0] idx;
      idx      = '0;
      pick     = '0;
      pick_idx = '0;
      valid    = 1'b0;
      // k runs 1..NREQ so the last candidate examined is ptr itself.
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = PW'((32'(ptr) + k) % NREQ);
         if (!valid && req[idx]) begin
            valid     = 1'b1;
            pick[idx] = 1'b1;
            pick_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side scheduler for the dual-clock FIFO (read clock domain only).
// Shares the single show-ahead FIFO read port between NREQ consumers in round-robin order;
// each grant drains one burst of (req_len slice + 1) beats.
// Optional feature macro: RD_STALL_TIMEOUT_EN (abort a burst after TIMEOUT stalled cycles).
//   rclk, rrst_n : clock, asynchronous active-low reset
//   req, req_len : per-consumer burst request and length-1
//   rempty, rdata: FIFO empty flag and show-ahead data
//   rinc         : FIFO pop strobe
//   gnt          : registered one-hot grant
//   out_data     : rdata forwarded to consumers
//   out_valid    : one-hot beat valid; out_ready: per-consumer accept
//   burst_done   : one-cycle pulse at burst end; burst_abort: pulse when ended by timeout
module fifo_rd_arbiter
   import fifo_rd_arb_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned DSIZE   = 8,
   parameter int unsigned BLEN_W  = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                     rclk,
   input  logic                     rrst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*BLEN_W-1:0]   req_len,
   input  logic                     rempty,
   input  logic [DSIZE-1:0]         rdata,
   output logic                     rinc,
   output logic [NREQ-1:0]          gnt,
   output logic [DSIZE-1:0]         out_data,
   output logic [NREQ-1:0]          out_valid,
   input  logic [NREQ-1:0]          out_ready,
   output logic [NREQ-1:0]          burst_done,
   output logic                     burst_abort
);

   localparam int unsigned   PW      = idx_w(NREQ);
   localparam logic [PW-1:0] PTR_RST = PW'(rst_ptr(NREQ));

   arb_state_e        state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     gidx_q, gidx_d;
   logic [BLEN_W-1:0] len_q, len_d;
   logic [BLEN_W-1:0] cnt_q, cnt_d;
   logic [BLEN_W-1:0] len_sel;
   logic [NREQ-1:0]   pick;
   logic [PW-1:0]     pick_idx;
   logic              pick_valid;
   logic              in_burst;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .req      (req),
      .ptr      (ptr_q),
      .pick     (pick),
      .pick_idx (pick_idx),
      .valid    (pick_valid)
   );

   always_comb begin
      len_sel = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick[i]) len_sel = req_len[i*BLEN_W +: BLEN_W];
      end
   end

   // gnt_q is only non-zero in StBurst, so it selects the granted consumer directly.
   assign in_burst   = (state_q == StBurst);
   assign rinc       = in_burst & ~rempty & |(gnt_q & out_ready);
   assign out_valid  = (in_burst && !rempty) ? gnt_q : '0;
   assign out_data   = rdata;
   assign gnt        = gnt_q;
   assign burst_done = (state_q == StDone) ? (NREQ'(1) << gidx_q) : '0;

`ifdef RD_STALL_TIMEOUT_EN
   localparam int unsigned SW = stall_w(TIMEOUT);
   logic [SW-1:0] stall_q, stall_d;
   logic          abort_q, abort_d;
   assign burst_abort = abort_q;
`else
   assign burst_abort = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
`ifdef RD_STALL_TIMEOUT_EN
      stall_d = stall_q;
      abort_d = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               state_d = StBurst;
               gnt_d   = pick;
               gidx_d  = pick_idx;
               len_d   = len_sel;
               cnt_d   = '0;
`ifdef RD_STALL_TIMEOUT_EN
               stall_d = '0;
`endif
            end
         end
         StBurst: begin
            if (rinc) begin
               // Compare before incrementing so an all-ones length never wraps the counter.
               if (cnt_q == len_q) begin
                  state_d = StDone;
                  gnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + BLEN_W'(1);
               end
`ifdef RD_STALL_TIMEOUT_EN
               stall_d = '0;
            end else if (stall_q == SW'(TIMEOUT - 1)) begin
               state_d = StDone;
               gnt_d   = '0;
               abort_d = 1'b1;
            end else begin
               stall_d = stall_q + SW'(1);
`endif
            end
         end
         StDone: begin
            ptr_d   = gidx_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         ptr_q   <= PTR_RST;
         gidx_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
`ifdef RD_STALL_TIMEOUT_EN
         stall_q <= '0;
         abort_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
`ifdef RD_STALL_TIMEOUT_EN
         stall_q <= stall_d;
         abort_q <= abort_d;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
module tb_fifo_rd_arbiter;
   localparam int NREQ    = 4;
   localparam int DSIZE   = 8;
   localparam int BLEN_W  = 4;
   localparam int TIMEOUT = 64;

   logic                   rclk = 1'b0;
   logic                   rrst_n = 1'b0;
   logic [NREQ-1:0]        req = '0;
   logic [NREQ*BLEN_W-1:0] req_len = '0;
   logic                   rempty = 1'b1;
   logic [DSIZE-1:0]       rdata = '0;
   logic                   rinc;
   logic [NREQ-1:0]        gnt;
   logic [DSIZE-1:0]       out_data;
   logic [NREQ-1:0]        out_valid;
   logic [NREQ-1:0]        out_ready = '1;
   logic [NREQ-1:0]        burst_done;
   logic                   burst_abort;

   fifo_rd_arbiter #(
      .NREQ(NREQ), .DSIZE(DSIZE), .BLEN_W(BLEN_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .rclk(rclk), .rrst_n(rrst_n), .req(req), .req_len(req_len), .rempty(rempty),
      .rdata(rdata), .rinc(rinc), .gnt(gnt), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .burst_done(burst_done), .burst_abort(burst_abort)
   );

   always #5 rclk = ~rclk;

   // FIFO contents (front = show-ahead word) and test bookkeeping.
   logic [DSIZE-1:0] fifo_q[$];
   logic [DSIZE-1:0] dut_seen[$];
   int               dut_grants[$];
   int               dut_gcyc[$];
   bit               force_empty = 1'b0;
   int               checks = 0, failures = 0;
   int               cyc = 0, done_cnt = 0, stall_cnt = 0, bad_pop = 0, abort_cnt = 0;
   logic [NREQ-1:0]  prev_gnt = '0;

   // Transaction-level reference: granted consumer, beats still owed, pending done pulse.
   int m_g, m_left, m_done_g, m_ptr, m_stall;
   bit m_abort;

   typedef struct {
      logic [NREQ-1:0]        req;
      logic [NREQ*BLEN_W-1:0] lens;
      int                     order[5];
      int                     gap;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_fifo();
      rempty = force_empty || (fifo_q.size() == 0);
      rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   task automatic model_reset();
      m_g = -1; m_done_g = -1; m_ptr = NREQ - 1; m_stall = 0; m_abort = 0;
   endtask

   // Called at a falling edge: check outputs, advance the model over the next rising edge.
   task automatic step();
      logic [NREQ-1:0] eg, ev, ed;
      logic            er, ea;
      drive_fifo();
      #1;
      eg = (m_g >= 0) ? (NREQ'(1) << m_g) : '0;
      er = (m_g >= 0) && !rempty && out_ready[m_g];
      ev = (m_g >= 0 && !rempty) ? eg : '0;
      ed = (m_done_g >= 0) ? (NREQ'(1) << m_done_g) : '0;
      ea = (m_done_g >= 0) && m_abort;
      check("gnt", 32'(gnt), 32'(eg));
      check("rinc", 32'(rinc), 32'(er));
      check("out_valid", 32'(out_valid), 32'(ev));
      check("burst_done", 32'(burst_done), 32'(ed));
      check("burst_abort", 32'(burst_abort), 32'(ea));
      if (ev != '0) check("out_data", 32'(out_data), 32'(fifo_q[0]));
      // DUT-side observations.
      if (rinc) dut_seen.push_back(out_data);
      if (rinc && rempty) bad_pop++;
      if (burst_done != '0) done_cnt++;
      if (burst_abort) abort_cnt++;
      if (gnt != '0 && !rempty && out_valid == '0) bad_pop++;
      if (gnt != '0 && rempty) stall_cnt++;
      if (gnt != '0 && prev_gnt == '0) begin
         for (int i = 0; i < NREQ; i++) if (gnt[i]) dut_grants.push_back(i);
         dut_gcyc.push_back(cyc);
      end
      prev_gnt = gnt;
      // Advance the reference.
      if (m_done_g >= 0) begin
         m_ptr = m_done_g; m_done_g = -1; m_abort = 0;
      end else if (m_g >= 0) begin
         if (er) begin
            void'(fifo_q.pop_front());
            m_left--; m_stall = 0;
         end else begin
            m_stall++;
         end
         if (m_left == 0) begin
            m_done_g = m_g; m_g = -1;
         end
`ifdef RD_STALL_TIMEOUT_EN
         else if (m_stall == TIMEOUT) begin
            m_done_g = m_g; m_g = -1; m_abort = 1;
         end
`endif
      end else begin
         for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req[i]) begin
               m_g = i; m_left = int'(req_len[i*BLEN_W +: BLEN_W]) + 1; m_stall = 0;
               break;
            end
         end
      end
      @(posedge rclk);
      #1 drive_fifo();
      @(negedge rclk);
      cyc++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rrst_n = 1'b0;
      #1;
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_rinc", 32'(rinc), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_done", 32'(burst_done), 32'h0);
      model_reset();
      prev_gnt = '0;
      @(negedge rclk);
      rrst_n = 1'b1;
      dut_seen.delete(); dut_grants.delete(); dut_gcyc.delete();
      done_cnt = 0; stall_cnt = 0;
   endtask

   task automatic fill(input int n, input logic [DSIZE-1:0] base);
      for (int i = 0; i < n; i++) fifo_q.push_back(base + DSIZE'(i));
   endtask

   initial begin
      vecs[0] = '{4'b1111, 16'h0000, '{0, 1, 2, 3, 0}, 3};
      vecs[1] = '{4'b1010, 16'h0000, '{1, 3, 1, 3, 1}, 3};
      vecs[2] = '{4'b0100, 16'h0000, '{2, 2, 2, 2, 2}, 3};
      vecs[3] = '{4'b1001, 16'h0000, '{0, 3, 0, 3, 0}, 3};
      vecs[4] = '{4'b0110, 16'h0110, '{1, 2, 1, 2, 1}, 4};

      model_reset();
      @(negedge rclk);
      do_reset();

      // Single 4-beat burst to consumer 0.
      fifo_q.delete();
      fifo_q.push_back(8'hA1); fifo_q.push_back(8'hB2);
      fifo_q.push_back(8'hC3); fifo_q.push_back(8'hD4);
      req = 4'b0001; req_len = 16'h0003;
      step();
      req = '0;
      steps(8);
      check("t1_beats", 32'(dut_seen.size()), 32'd4);
      if (dut_seen.size() == 4) begin
         check("t1_d0", 32'(dut_seen[0]), 32'hA1);
         check("t1_d1", 32'(dut_seen[1]), 32'hB2);
         check("t1_d2", 32'(dut_seen[2]), 32'hC3);
         check("t1_d3", 32'(dut_seen[3]), 32'hD4);
      end
      check("t1_done_pulses", 32'(done_cnt), 32'd1);
      check("t1_gnt_idle", 32'(gnt), 32'h0);

      // Round-robin order table.
      for (int v = 0; v < 5; v++) begin
         do_reset();
         fifo_q.delete();
         fill(40, 8'h10);
         req = vecs[v].req; req_len = vecs[v].lens;
         for (int c = 0; c < 40 && dut_grants.size() < 5; c++) step();
         check("rr_grant_count", 32'(dut_grants.size()), 32'd5);
         for (int i = 0; i < dut_grants.size() && i < 5; i++)
            check("rr_order", 32'(dut_grants[i]), 32'(vecs[v].order[i]));
         for (int i = 1; i < dut_gcyc.size() && i < 5; i++)
            check("rr_gap", 32'(dut_gcyc[i] - dut_gcyc[i-1]), 32'(vecs[v].gap));
      end
      req = '0;

      // Stall on empty FIFO mid-burst.
      do_reset();
      fifo_q.delete();
      fill(2, 8'h50);
      req = 4'b0100; req_len = 16'h0500;
      step();
      req = '0;
      steps(12);
      check("stall_cycles", 32'(stall_cnt), 32'd10);
      fill(4, 8'h52);
      steps(8);
      check("stall_beats", 32'(dut_seen.size()), 32'd6);
      for (int i = 0; i < dut_seen.size() && i < 6; i++)
         check("stall_data", 32'(dut_seen[i]), 32'h50 + 32'(i));
      check("stall_done", 32'(done_cnt), 32'd1);

      // out_ready back-pressure on consumer 1.
      do_reset();
      fifo_q.delete();
      fill(8, 8'h70);
      req = 4'b0010; req_len = 16'h0030;
      step();
      req = '0;
      begin
         logic [7:0] pat;
         pat = 8'b1111_1001;
         for (int i = 0; i < 8; i++) begin
            out_ready = NREQ'($urandom);
            out_ready[1] = pat[i];
            step();
         end
      end
      out_ready = '1;
      steps(2);
      check("bp_beats", 32'(dut_seen.size()), 32'd4);
      for (int i = 0; i < dut_seen.size() && i < 4; i++)
         check("bp_data", 32'(dut_seen[i]), 32'h70 + 32'(i));
      check("bp_done", 32'(done_cnt), 32'd1);

      // Reset in the middle of a burst; pointer must return to its reset value.
      do_reset();
      fifo_q.delete();
      fill(20, 8'h90);
      req = 4'b0010; req_len = 16'h0000;
      step();
      req = '0;
      steps(3);
      req = 4'b0100; req_len = 16'h0700;
      step();
      req = '0;
      steps(2);
      check("mid_gnt_before", 32'(gnt), 32'h4);
      do_reset();
      req = 4'b1111; req_len = '0;
      steps(3);
      check("mid_first_grant", 32'(dut_grants.size() > 0 ? dut_grants[0] : -1), 32'd0);
      req = '0;

`ifdef RD_STALL_TIMEOUT_EN
      do_reset();
      fifo_q.delete();
      abort_cnt = 0;
      req = 4'b0001; req_len = '0;
      step();
      req = 4'b0010;
      steps(TIMEOUT + 4);
      check("to_abort_pulse", 32'(abort_cnt), 32'd1);
      check("to_next_grant", 32'(dut_grants.size() > 1 ? dut_grants[1] : -1), 32'd1);
      req = '0;
`endif

      // Randomized traffic against the reference.
      do_reset();
      fifo_q.delete();
      bad_pop = 0;
      for (int c = 0; c < 800; c++) begin
         req         = NREQ'($urandom);
         req_len     = (NREQ*BLEN_W)'($urandom);
         out_ready   = NREQ'($urandom);
         force_empty = ($urandom_range(3) == 0);
         if ($urandom_range(1) == 1 && fifo_q.size() < 12) fifo_q.push_back(DSIZE'($urandom));
         step();
      end
      force_empty = 1'b0;
      check("rand_no_bad_pop", 32'(bad_pop), 32'd0);
      check("rand_some_bursts", 32'(done_cnt > 10), 32'd1);
`ifndef RD_STALL_TIMEOUT_EN
      check("no_abort", 32'(abort_cnt), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
